// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared nibble width, FSM state and nibble type for the serial adder
//
// Purpose : common definitions for nibble_serial_adder and its cla_nibble slice.
// Contents: NIB_W   - width of one arithmetic slice (4 bits)
//           state_t - sequencer states IDLE / RUN / DONE
//           nibble_t- one 4-bit operand/sum nibble
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/cla_nibble.sv
// rtl/cla_nibble.sv - combinational 4-bit carry-lookahead adder slice
//
// Purpose : y = a + b + cin over one nibble, carries formed by lookahead
//           (no ripple through the slice).
// Ports   : a, b  in  4  nibble operands
//           cin   in  1  carry into bit 0
//           y     out 4  nibble sum
//           cout  out 1  carry out of bit 3
module cla_nibble
  import cla_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t y,
  output logic    cout
);

  nibble_t          w_g;
  nibble_t          w_p;
  logic [NIB_W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat sum of products of generate/propagate terms.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign y    = w_p ^ w_c[NIB_W-1:0];
  assign cout = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide adder that reuses one 4-bit CLA slice, one nibble per clock
//
// Purpose : captures a, b, cin on an accepted start, then adds nibble 0..NNIB-1
//           on successive clocks through a single cla_nibble, carrying the slice
//           carry-out in a register between nibbles.
// Ports   : clk   in  1      clock, rising edge
//           rst   in  1      asynchronous active-high reset
//           start in  1      request, sampled in IDLE or DONE
//           a, b  in  WIDTH  operands
//           cin   in  1      carry into nibble 0
//           busy  out 1      high in RUN
//           done  out 1      one-cycle pulse, y/cout valid
//           y     out WIDTH  sum
//           cout  out 1      carry out of the top nibble
//           ovf   out 1      signed overflow (only when OVERFLOW_EN is defined)
// Macro   : OVERFLOW_EN adds the ovf port and its register.
module nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NNIB  = WIDTH / 4
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout
`ifdef OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;

  nibble_t          w_nib_a;
  nibble_t          w_nib_b;
  nibble_t          w_nib_y;
  logic             w_nib_cout;

  assign w_nib_a = r_a[int'(r_idx)*NIB_W +: NIB_W];
  assign w_nib_b = r_b[int'(r_idx)*NIB_W +: NIB_W];
  assign w_last  = (r_idx == IDX_W'(NNIB - 1));

  cla_nibble u_slice (
    .a    (w_nib_a),
    .b    (w_nib_b),
    .cin  (r_carry),
    .y    (w_nib_y),
    .cout (w_nib_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DONE accepts a new start exactly like IDLE, so back-to-back adds need no bubble.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_y[int'(r_idx)*NIB_W +: NIB_W] <= w_nib_y;
      r_carry <= w_nib_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_nib_cout;
      end
    end
  end

  assign y    = r_y;
  assign cout = r_cout;

`ifdef OVERFLOW_EN
  logic r_ovf;

  // Carry into the sum MSB is recovered from the top slice as a^b^y of bit 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= w_nib_cout ^ (w_nib_a[NIB_W-1] ^ w_nib_b[NIB_W-1] ^ w_nib_y[NIB_W-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder
module tb_nibble_serial_adder;

  localparam int W  = 16;
  localparam int NN = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         cout;
  logic         ovf;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .cout  (cout)
`ifdef OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

`ifndef OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
    int           dcyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   run_from = -100;
  int   last_c0  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input int dc);
    exp_t          e;
    logic [W:0]    s;
    longint        ss;
    s  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    ss = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
    e.y    = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (ss > longint'((1 << (W-1)) - 1)) || (ss < -longint'(1 << (W-1)));
    e.dcyc = dc;
    return e;
  endfunction

  // Called at a negedge where the DUT is in IDLE or DONE; returns one negedge later.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    start   = 1'b1;
    a       = ia;
    b       = ib;
    cin     = ic;
    last_c0 = cyc + 1;
    run_from = last_c0;
    sb.push_back(model(ia, ib, ic, last_c0 + NN));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done();
    wait_until(last_c0 + NN);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy", busy, (cyc >= run_from) && (cyc < run_from + NN));
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("y", y, e.y);
          chk("cout", cout, e.cout);
`ifdef OVERFLOW_EN
          chk("ovf", ovf, e.ovf);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dummy;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_y", y, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done();
    @(negedge clk);

    issue(16'h1234, 16'h4321, 1'b1);
    wait_done();
    @(negedge clk);

    // start during RUN with other operands must be ignored
    issue(16'hA5A5, 16'h0F0F, 1'b0);
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // back-to-back: second start presented in DONE
    issue(16'h1111, 16'h2222, 1'b0);
    wait_done();
    issue(16'h00FF, 16'h0001, 1'b0);
    wait_done();
    @(negedge clk);

    // reset after two RUN cycles aborts without a done
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    dummy = sb.pop_back();
    run_from = -100;
    #1;
    chk("abort_y", y, 0);
    chk("abort_cout", cout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_done2", done, 0);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h0001, 16'h0001, 1'b0);
    wait_done();
    @(negedge clk);

`ifdef OVERFLOW_EN
    issue(16'h7FFF, 16'h0001, 1'b0);
    wait_done();
    @(negedge clk);
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done();
    @(negedge clk);
`endif

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_done();
      if ($urandom_range(1, 0) == 0) begin
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
    end

    repeat (NN + 3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
